pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Sequencing controller in front of `pc_reg` that merges the four redirect sources (trap/CLINT, EXU branch, IFU special, BPU) into a single prioritized redirect. Redirects arriving while the front end is stalled are captured and replayed, so none is lost. Every issued redirect produces a fetch-flush pulse and an epoch tag that lets the IFU/icache discard in-flight responses from the old stream. Sits between the redirect producers (EXU, MEM/CLINT, IFU, BPU) and `pc_reg`/IFU.

## Interface
Parameters:
- `PC_W`, 32, width of every PC value (matches `INST_LEN`/`XLEN`).
- `EPOCH_W`, 2, width of the epoch tag.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `clint_pc_i` in PC_W / `clint_pc_valid_i` in 1: trap redirect, priority 3 (highest).
- `branch_pc_i` in PC_W / `branch_pc_valid_i` in 1: EXU branch redirect, priority 2.
- `ifu_special_pc_i` in PC_W / `ifu_special_valid_i` in 1: IFU cross-boundary refetch, priority 1.
- `bpu_pc_i` in PC_W / `bpu_pc_valid_i` in 1: BPU predicted target, priority 0.
- `stall_valid_i` in 1: front-end stall, same signal that drives `pc_reg`.
- `redir_pc_o` out PC_W: selected redirect target, bit 0 forced to 0.
- `redir_valid_o` out 1: redirect issued this cycle.
- `redir_src_o` out 2: source of the issued redirect (3 = trap, 2 = branch, 1 = ifu_special, 0 = bpu).
- `flush_fetch_o` out 1: one-cycle pulse, coincident with every `redir_valid_o`.
- `epoch_o` out EPOCH_W: current fetch epoch.

## Operation
- Incoming selection: highest-priority valid input wins. Lower-priority inputs in the same cycle are dropped, because they are younger and wrong-path.
- State machine has two states, IDLE and HOLD, plus a pending register {pend_pc, pend_src}.
- IDLE, incoming redirect, `stall_valid_i`=0: issue it combinationally in the same cycle. Stay in IDLE.
- IDLE, incoming ifu_special only, `stall_valid_i`=1: issue immediately. IFU special redirects bypass stall, consistent with `pc_reg`.
- IDLE, incoming trap/branch/bpu, `stall_valid_i`=1: capture into the pending register and go to HOLD. Issue nothing.
- HOLD, no incoming redirect: while `stall_valid_i`=1, hold. On the first cycle with `stall_valid_i`=0, issue the pending redirect and return to IDLE.
- HOLD with an incoming redirect:
  - If the new priority is greater than or equal to the pending priority, the new redirect replaces the pending one (same priority: newest wins).
  - If the new priority is lower, the new redirect is dropped.
  - The result is then issued or held per the stall rules above.
  - An incoming ifu_special while a pending trap or branch exists is dropped.
- Output values when `redir_valid_o`=0: `redir_pc_o`=0 and `redir_src_o`=0.
- Epoch: `epoch_o` increments by 1, modulo 2^EPOCH_W, on the clock edge following each issued redirect. It wraps 3→0.

## Timing
- Reset values: state IDLE, pending register cleared, `epoch_o`=0. All outputs are 0 during and after reset until a redirect occurs.
- Reset in HOLD discards the pending redirect; nothing is issued.
- Latency:
  - Unstalled redirect: 0 cycles (combinational path from input valid to `redir_valid_o`).
  - Held redirect: issued in the same cycle `stall_valid_i` falls.
- At most one redirect is issued per cycle. `flush_fetch_o` equals `redir_valid_o`.
- `epoch_o` is registered. During the issue cycle it shows the old epoch; the new epoch is visible from the next cycle on.
- Inputs are single-cycle pulses. The controller never requires a producer to hold a valid.

## Configuration
- `PC_REDIRECT_EPOCH_EN` defined: the epoch counter is built and `epoch_o` behaves as described.
- `PC_REDIRECT_EPOCH_EN` undefined: the counter is removed and `epoch_o` is tied to 0. The IFU then relies only on `flush_fetch_o`. All other behaviour is identical.

## Structure
- Shared package `pc_redirect_pkg` holds:
  - source encodings `REDIR_SRC_TRAP`=3, `REDIR_SRC_BRANCH`=2, `REDIR_SRC_IFU`=1, `REDIR_SRC_BPU`=0;
  - the state enum {IDLE, HOLD};
  - the `EPOCH_W` default.
- One sub-module: `redir_prio_sel`, a combinational four-way priority select producing {valid, pc, src}. It is instantiated once for the incoming inputs, and a compare against pend_src decides replacement.
- The pending register and the epoch register use `regTemplate` with synchronous reset.

## Test plan
- Unstalled branch 0x8000_0100 → `redir_valid_o`=1, pc 0x8000_0100, src 2 and `flush_fetch_o`=1 in the same cycle; `epoch_o` 0→1 on the next cycle.
- Stall=1, bpu 0x8000_0040 captured; 3 cycles later branch 0x8000_0200 arrives; stall falls 2 cycles after that → a single issue of 0x8000_0200 with src 2; bpu never issued.
- Stall=1, pending branch 0x8000_0200, then bpu 0x8000_0300 arrives → bpu dropped; on stall release 0x8000_0200 is issued.
- Trap 0x8000_0004 and branch 0x8000_0200 in the same cycle, unstalled → only trap issued, src 3.
- Stall=1 with no pending redirect, ifu_special 0x8000_0102 → issued immediately at 0x8000_0102 with src 1. Odd target 0x8000_0103 → 0x8000_0102.
- Five unstalled redirects → `epoch_o` goes 1, 2, 3, 0, 1. Rst asserted in HOLD → no issue after reset, `epoch_o`=0. Without `PC_REDIRECT_EPOCH_EN`, `epoch_o` stays 0 throughout.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// Shared encodings for the PC redirect controller: source priorities, FSM states, epoch width.
// Pure declarations, no logic.
package pc_redirect_pkg;

    localparam logic [1:0] REDIR_SRC_TRAP   = 2'd3;
    localparam logic [1:0] REDIR_SRC_BRANCH = 2'd2;
    localparam logic [1:0] REDIR_SRC_IFU    = 2'd1;
    localparam logic [1:0] REDIR_SRC_BPU    = 2'd0;

    localparam int EPOCH_W_DEFAULT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } redir_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Four-way fixed-priority redirect select (trap > branch > ifu_special > bpu).
// Purely combinational; no backpressure.
module redir_prio_sel
    import pc_redirect_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            trap_vld,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            branch_vld,
    input  logic [PC_W-1:0] branch_pc,
    input  logic            ifu_vld,
    input  logic [PC_W-1:0] ifu_pc,
    input  logic            bpu_vld,
    input  logic [PC_W-1:0] bpu_pc,
    output logic            sel_vld,
    output logic [PC_W-1:0] sel_pc,
    output logic [1:0]      sel_src
);

    always_comb begin
        sel_vld = 1'b1;
        sel_pc  = '0;
        sel_src = REDIR_SRC_BPU;
        if (trap_vld) begin
            sel_pc  = trap_pc;
            sel_src = REDIR_SRC_TRAP;
        end else if (branch_vld) begin
            sel_pc  = branch_pc;
            sel_src = REDIR_SRC_BRANCH;
        end else if (ifu_vld) begin
            sel_pc  = ifu_pc;
            sel_src = REDIR_SRC_IFU;
        end else if (bpu_vld) begin
            sel_pc  = bpu_pc;
            sel_src = REDIR_SRC_BPU;
        end else begin
            sel_vld = 1'b0;
        end
    end

endmodule

// File: rtl/regTemplate.sv
// Generic W-bit register with synchronous active-high reset to RST_VAL.
// Latency 1 cycle; no backpressure.
module regTemplate #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Merges four redirect sources into one prioritized redirect; stalled redirects are held and replayed.
// Latency 0 (combinational issue); stall holds the pending redirect, ifu_special bypasses stall.
// PC_REDIRECT_EPOCH_EN builds the epoch counter; otherwise epoch_o is tied to 0.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int EPOCH_W = EPOCH_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    clint_pc_i,
    input  logic               clint_pc_valid_i,
    input  logic [PC_W-1:0]    branch_pc_i,
    input  logic               branch_pc_valid_i,
    input  logic [PC_W-1:0]    ifu_special_pc_i,
    input  logic               ifu_special_valid_i,
    input  logic [PC_W-1:0]    bpu_pc_i,
    input  logic               bpu_pc_valid_i,
    input  logic               stall_valid_i,
    output logic [PC_W-1:0]    redir_pc_o,
    output logic               redir_valid_o,
    output logic [1:0]         redir_src_o,
    output logic               flush_fetch_o,
    output logic [EPOCH_W-1:0] epoch_o
);

    logic            in_vld;
    logic [PC_W-1:0] in_pc;
    logic [1:0]      in_src;

    redir_state_e    state_q, state_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic [1:0]      pend_src_q, pend_src_d;

    logic            cand_vld;
    logic [PC_W-1:0] cand_pc;
    logic [1:0]      cand_src;

    logic            iss_vld;
    logic [PC_W-1:0] iss_pc;
    logic [1:0]      iss_src;

    redir_prio_sel #(.PC_W(PC_W)) u_in_sel (
        .trap_vld   (clint_pc_valid_i),
        .trap_pc    (clint_pc_i),
        .branch_vld (branch_pc_valid_i),
        .branch_pc  (branch_pc_i),
        .ifu_vld    (ifu_special_valid_i),
        .ifu_pc     (ifu_special_pc_i),
        .bpu_vld    (bpu_pc_valid_i),
        .bpu_pc     (bpu_pc_i),
        .sel_vld    (in_vld),
        .sel_pc     (in_pc),
        .sel_src    (in_src)
    );

    always_comb begin
        state_d    = state_q;
        pend_pc_d  = pend_pc_q;
        pend_src_d = pend_src_q;
        iss_vld    = 1'b0;
        iss_pc     = '0;
        iss_src    = REDIR_SRC_BPU;

        cand_vld = in_vld;
        cand_pc  = in_pc;
        cand_src = in_src;
        // A held redirect survives unless a same-or-higher priority one arrives.
        if (state_q == HOLD) begin
            cand_vld = 1'b1;
            if (!in_vld || (in_src < pend_src_q)) begin
                cand_pc  = pend_pc_q;
                cand_src = pend_src_q;
            end
        end

        if (cand_vld && !rst) begin
            if (!stall_valid_i || (cand_src == REDIR_SRC_IFU)) begin
                iss_vld    = 1'b1;
                iss_pc     = cand_pc;
                iss_src    = cand_src;
                state_d    = IDLE;
                pend_pc_d  = '0;
                pend_src_d = REDIR_SRC_BPU;
            end else begin
                pend_pc_d  = cand_pc;
                pend_src_d = cand_src;
                state_d    = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    regTemplate #(.W(PC_W + 2)) u_pend_reg (
        .clk (clk),
        .rst (rst),
        .d   ({pend_pc_d, pend_src_d}),
        .q   ({pend_pc_q, pend_src_q})
    );

    assign redir_valid_o = iss_vld;
    assign flush_fetch_o = iss_vld;
    assign redir_pc_o    = {iss_pc[PC_W-1:1], 1'b0};
    assign redir_src_o   = iss_src;

`ifdef PC_REDIRECT_EPOCH_EN
    logic [EPOCH_W-1:0] epoch_q, epoch_d;

    always_comb begin
        epoch_d = epoch_q + EPOCH_W'(iss_vld);
    end

    regTemplate #(.W(EPOCH_W)) u_epoch_reg (
        .clk (clk),
        .rst (rst),
        .d   (epoch_d),
        .q   (epoch_q)
    );

    assign epoch_o = epoch_q;
`else
    assign epoch_o = '0;
`endif

endmodule
